// File: rtl/uart_pkg.sv
// Shared 8N1 constants, receiver state encoding and bit-timing helpers
// for the challenge/response UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  // Rounded clocks per bit; f_mhz in MHz, baud in bit/s.
  function automatic int bit_cycles(input int f_mhz, input int baud);
    return (f_mhz * 1000000 + baud / 2) / baud;
  endfunction

  function automatic int half_cycles(input int f_mhz, input int baud);
    return bit_cycles(f_mhz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte deserialiser: two-flop synchroniser, start-bit qualification,
// LSB-first data capture and stop-bit check.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int FREQ_MHZ = 16,
  parameter int BAUD     = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_done_o,
  output logic       frame_error_o,
  output logic       idle_o
);

  localparam int BITC = bit_cycles(FREQ_MHZ, BAUD);
  localparam int HALF = half_cycles(FREQ_MHZ, BAUD);
  localparam int CW   = $clog2(BITC + 1);

  // The IDLE->START hop and the START count together span HALF clocks.
  localparam logic [CW-1:0] START_END = CW'(HALF - 2);
  localparam logic [CW-1:0] BIT_END   = CW'(BITC - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bits_q, bits_d;
  logic [7:0]    shift_q, shift_d;
  logic          done, ferr;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bits_d  = bits_q;
    shift_d = shift_q;
    done    = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == START_END) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bits_d  = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bits_d  = bits_q + 4'd1;
          if (bits_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rx_s == STOP_LEVEL) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o        = shift_q;
  assign byte_done_o   = done;
  assign frame_error_o = ferr;
  assign idle_o        = (state_q == IDLE);

endmodule

// File: rtl/uart_challenge_rx.sv
// Challenge receive front end: packs UART bytes into a challenge word and
// hands it to the evaluator over valid/ready, with gap timeout and overrun.
module uart_challenge_rx
  import uart_pkg::*;
#(
  parameter int frequency_clk_ref = 16,
  parameter int baud_rate         = 115200,
  parameter int Challenge_Bit     = 8,
  parameter int gap_bits          = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  output logic [Challenge_Bit-1:0] challenge,
  output logic                     challenge_valid,
  input  logic                     challenge_ready,
  output logic                     frame_error,
  output logic                     overrun
);

  localparam int NB   = Challenge_Bit / 8;
  localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int BITC = bit_cycles(frequency_clk_ref, baud_rate);
  localparam int GAP  = gap_bits * BITC;
  localparam int GW   = $clog2(GAP + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP - 1);

  logic [7:0] rx_byte;
  logic       byte_done, ferr, idle;

  uart_byte_rx #(
    .FREQ_MHZ(frequency_clk_ref),
    .BAUD    (baud_rate)
  ) u_byte (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (uart_rx),
    .byte_o       (rx_byte),
    .byte_done_o  (byte_done),
    .frame_error_o(ferr),
    .idle_o       (idle)
  );

  logic [IW-1:0]            idx_q, idx_d;
  logic [Challenge_Bit-1:0] asm_q, asm_d;
  logic [Challenge_Bit-1:0] chal_q, chal_d;
  logic [Challenge_Bit-1:0] word;
  logic                     valid_q, valid_d;
  logic                     ferr_q;
  logic                     ovr_q, ovr_d;
  logic [GW-1:0]            gap_q, gap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      asm_q   <= '0;
      chal_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      chal_q  <= chal_d;
      valid_q <= valid_d;
      ferr_q  <= ferr;
      ovr_q   <= ovr_d;
      gap_q   <= gap_d;
    end
  end

  // Assembly register with the incoming byte merged into its lane.
  always_comb begin
    word = asm_q;
    word[{idx_q, 3'b000} +: 8] = rx_byte;
  end

  always_comb begin
    idx_d   = idx_q;
    asm_d   = asm_q;
    chal_d  = chal_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    gap_d   = '0;
    if (valid_q && challenge_ready) valid_d = 1'b0;
    if (ferr) begin
      idx_d = '0;
    end else if (byte_done) begin
      asm_d = word;
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (!valid_q || challenge_ready) begin
          chal_d  = word;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else if (idle && idx_q != '0) begin
      if (gap_q == GAP_END) idx_d = '0;
      else gap_d = gap_q + GW'(1);
    end
  end

  assign challenge       = chal_q;
  assign challenge_valid = valid_q;
  assign frame_error     = ferr_q;
  assign overrun         = ovr_q;

endmodule
